// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every downstream domain in reset, then releases them one
// at a time in ascending order, each after its own programmable delay.
module reset_sequencer #(
    parameter int NUM_DOM  = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     SW_RST,
    input  logic [NUM_DOM*CNT_W-1:0] DLY_CFG,
    output logic [NUM_DOM-1:0]       DOM_RST_N,
    output logic                     SEQ_DONE,
    output logic                     BUSY
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOM - 1);

    typedef enum logic [1:0] {HOLD, WAIT, DONE} state_t;

    state_t                          state, state_nxt;
    logic [CNT_W-1:0]                cnt, cnt_nxt;
    logic [IDX_W-1:0]                idx, idx_nxt;
    logic [NUM_DOM-1:0]              dom_nxt;
    logic                            done_nxt, busy_nxt;
    logic [NUM_DOM-1:0][CNT_W-1:0]   dly;
    logic [CNT_W-1:0]                cur_dly;

    for (genvar i = 0; i < NUM_DOM; i++) begin : g_dly
        assign dly[i] = DLY_CFG[i*CNT_W +: CNT_W];
    end

    // Delay is read live so a shortened value takes effect on the next edge.
    assign cur_dly = dly[idx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        dom_nxt   = DOM_RST_N;
        done_nxt  = SEQ_DONE;
        busy_nxt  = BUSY;
        if (SW_RST) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            dom_nxt   = '0;
            done_nxt  = 1'b0;
            busy_nxt  = 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    dom_nxt  = '0;
                    done_nxt = 1'b0;
                    busy_nxt = 1'b1;
                    if (cnt == HOLD_LAST) begin
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = WAIT;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // cnt stops at cur_dly, so it can never wrap.
                    if (cnt >= cur_dly) begin
                        dom_nxt[idx] = 1'b1;
                        cnt_nxt      = '0;
                        if (idx == LAST_IDX) begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DONE: begin
                    dom_nxt  = '1;
                    done_nxt = 1'b1;
                    busy_nxt = 1'b0;
                end
                default: begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    dom_nxt   = '0;
                    done_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            DOM_RST_N <= '0;
            SEQ_DONE  <= 1'b0;
            BUSY      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            DOM_RST_N <= dom_nxt;
            SEQ_DONE  <= done_nxt;
            BUSY      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized delays and soft resets,
// checked against closed-form release times computed from the delay fields.
module tb_reset_sequencer;

    localparam int NUM_DOM  = 4;
    localparam int CNT_W    = 8;
    localparam int HOLD_CYC = 16;

    logic                     CLK = 1'b0;
    logic                     RST;
    logic                     SW_RST;
    logic [NUM_DOM*CNT_W-1:0] DLY_CFG;
    logic [NUM_DOM-1:0]       DOM_RST_N;
    logic                     SEQ_DONE;
    logic                     BUSY;

    int nvec = 0;
    int nerr = 0;

    reset_sequencer #(.NUM_DOM(NUM_DOM), .CNT_W(CNT_W), .HOLD_CYC(HOLD_CYC)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_RST    (SW_RST),
        .DLY_CFG   (DLY_CFG),
        .DOM_RST_N (DOM_RST_N),
        .SEQ_DONE  (SEQ_DONE),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    // Domain i is released once n counting edges have elapsed, where
    // rel_i = HOLD_CYC + sum_{j<=i} (D_j + 1); n = 0 means "just reset".
    function automatic logic [NUM_DOM-1:0] exp_dom(input int n, input logic [NUM_DOM*CNT_W-1:0] c);
        logic [NUM_DOM-1:0] r;
        int t;
        r = '0;
        t = HOLD_CYC;
        for (int i = 0; i < NUM_DOM; i++) begin
            t = t + int'(c[i*CNT_W +: CNT_W]) + 1;
            if (n >= t) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [NUM_DOM+1:0] exp_all(input int n, input logic [NUM_DOM*CNT_W-1:0] c);
        logic [NUM_DOM-1:0] d;
        d = exp_dom(n, c);
        return {d, &d, ~&d};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        SW_RST = 1'b0;
        #1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST     = 1'b1;
        SW_RST  = 1'b0;
        DLY_CFG = {8'd2, 8'd1, 8'd3, 8'd0};
        #3;
        nvec++;
        if ({DOM_RST_N, SEQ_DONE, BUSY} !== {4'b0000, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset_state: got %b exp %b", {DOM_RST_N, SEQ_DONE, BUSY}, 6'b000001);
        end
        step();
        step();
        nvec++;
        if ({DOM_RST_N, SEQ_DONE, BUSY} !== {4'b0000, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL reset_held: got %b exp %b", {DOM_RST_N, SEQ_DONE, BUSY}, 6'b000001);
        end
    endtask

    task automatic test_basic_seq(input logic [NUM_DOM*CNT_W-1:0] c, input string name);
        logic [NUM_DOM+1:0] ev;
        DLY_CFG = c;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            step();
            ev = exp_all(e, c);
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                nerr++;
                $display("FAIL %s edge %0d: got %b exp %b", name, e, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
            end
        end
    endtask

    task automatic test_sw_rst_done();
        logic [NUM_DOM+1:0] ev;
        // Entered with the sequence finished.
        SW_RST = 1'b1;
        step();
        SW_RST = 1'b0;
        nvec++;
        if ({DOM_RST_N, SEQ_DONE, BUSY} !== {4'b0000, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL sw_rst_done_clear: got %b exp %b", {DOM_RST_N, SEQ_DONE, BUSY}, 6'b000001);
        end
        for (int n = 1; n <= 30; n++) begin
            step();
            ev = exp_all(n, DLY_CFG);
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                nerr++;
                $display("FAIL sw_rst_done_rerun n=%0d: got %b exp %b", n, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
            end
        end
    endtask

    task automatic test_sw_rst_wait();
        logic [NUM_DOM+1:0] ev;
        DLY_CFG = {8'd2, 8'd1, 8'd3, 8'd0};
        do_reset();
        for (int e = 1; e <= 22; e++) step();
        // Now waiting on domain 2 with domains 0 and 1 released.
        nvec++;
        if (DOM_RST_N !== 4'b0011) begin
            nerr++;
            $display("FAIL sw_rst_wait_pre: got %b exp %b", DOM_RST_N, 4'b0011);
        end
        SW_RST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== {4'b0000, 1'b0, 1'b1}) begin
                nerr++;
                $display("FAIL sw_rst_wait_held k=%0d: got %b exp %b", k, {DOM_RST_N, SEQ_DONE, BUSY}, 6'b000001);
            end
        end
        SW_RST = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            step();
            ev = exp_all(n, DLY_CFG);
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                nerr++;
                $display("FAIL sw_rst_wait_rerun n=%0d: got %b exp %b", n, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
            end
        end
    endtask

    task automatic test_async_rst();
        logic [NUM_DOM+1:0] ev;
        DLY_CFG = {8'd2, 8'd1, 8'd3, 8'd0};
        do_reset();
        for (int e = 1; e <= 22; e++) step();
        #2;
        RST = 1'b1;
        #1;
        // Still before edge 23: only the asynchronous path can have acted.
        nvec++;
        if ({DOM_RST_N, SEQ_DONE, BUSY} !== {4'b0000, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL async_rst: got %b exp %b", {DOM_RST_N, SEQ_DONE, BUSY}, 6'b000001);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int n = 1; n <= 27; n++) begin
            step();
            ev = exp_all(n, DLY_CFG);
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                nerr++;
                $display("FAIL async_rst_rerun n=%0d: got %b exp %b", n, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
            end
        end
    endtask

    task automatic test_live_cfg();
        logic [NUM_DOM+1:0] ev;
        logic [NUM_DOM-1:0] dv;
        DLY_CFG = {8'd0, 8'd0, 8'd200, 8'd0};
        do_reset();
        for (int e = 1; e <= 27; e++) begin
            step();
            ev = exp_all(e, DLY_CFG);
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                nerr++;
                $display("FAIL live_cfg_pre edge %0d: got %b exp %b", e, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
            end
        end
        // Ten cycles into domain 1's 200-cycle wait; shorten it below the count.
        DLY_CFG[1*CNT_W +: CNT_W] = 8'd5;
        for (int k = 0; k < 3; k++) begin
            step();
            dv = NUM_DOM'((1 << (k + 2)) - 1);
            ev = {dv, &dv, ~&dv};
            nvec++;
            if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                nerr++;
                $display("FAIL live_cfg_post edge %0d: got %b exp %b", 28 + k, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
            end
        end
    endtask

    task automatic test_random();
        logic [NUM_DOM+1:0] ev;
        logic [NUM_DOM-1:0] inc;
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NUM_DOM; i++)
                DLY_CFG[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 15));
            do_reset();
            n = 0;
            for (int e = 0; e < 120; e++) begin
                SW_RST = ($urandom_range(0, 39) == 0);
                if (SW_RST) begin
                    for (int i = 0; i < NUM_DOM; i++)
                        DLY_CFG[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 15));
                end
                step();
                n = SW_RST ? 0 : n + 1;
                ev = exp_all(n, DLY_CFG);
                nvec++;
                if ({DOM_RST_N, SEQ_DONE, BUSY} !== ev) begin
                    nerr++;
                    $display("FAIL random it=%0d e=%0d n=%0d: got %b exp %b", it, e, n, {DOM_RST_N, SEQ_DONE, BUSY}, ev);
                end
                inc = DOM_RST_N + 1'b1;
                nvec++;
                if ((inc & DOM_RST_N) !== '0) begin
                    nerr++;
                    $display("FAIL release_order it=%0d e=%0d: got %b exp contiguous low ones", it, e, DOM_RST_N);
                end
            end
            SW_RST = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic_seq({8'd2, 8'd1, 8'd3, 8'd0}, "seq_mixed");
        test_sw_rst_done();
        test_basic_seq('0, "seq_zero");
        test_sw_rst_wait();
        test_async_rst();
        test_live_cfg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete, got running exp finished");
        $fatal(1);
    end

endmodule
